sync_fifo_rd_packer: RTL
========================

// Module: sync_fifo_rd_packer
// PURPOSE
//  Read-side stage placed directly downstream of sync_fifo. It pops narrow words via the FIFO's valid/ready read port
//  and packs RATIO consecutive words into one wide output word with its own valid/ready handshake.
//  Partial words are emitted on explicit flush or after an idle timeout, tagged with a lane count and a last flag.
// PARAMETERS
//  DATA_WIDTH  `DATA_WIDTH  width of one narrow input word (matches sync_fifo DATA_WIDTH)
//  RATIO       4            narrow words per wide word; >=2
//  TIMEOUT     16           idle cycles with a partial word before auto-flush; 0 disables auto-flush
//  CNT_WIDTH   $clog2(RATIO+1)  width of lane count fields (derived)
// PORTS
//  i_clk       in   1                 clock, all logic on rising edge
//  i_rst_n     in   1                 asynchronous reset, active low
//  i_valid_s   in   1                 upstream word available (connect to FIFO o_valid_m)
//  i_datain    in   DATA_WIDTH        upstream word (connect to FIFO o_dataout)
//  o_ready_s   out  1                 stage accepts word this cycle (connect to FIFO i_ready_m)
//  i_flush     in   1                 single-cycle request to emit current partial word
//  o_valid_m   out  1                 wide word valid
//  o_dataout   out  RATIO*DATA_WIDTH  wide word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  o_lanes     out  CNT_WIDTH         number of valid lanes in o_dataout, 1..RATIO
//  o_last      out  1                 word was produced by flush/timeout (partial or not)
//  i_ready_m   in   1                 downstream consumes wide word
//  o_busy      out  1                 1 when any partial data held or output word pending
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): lane_cnt=0, accumulator=0, flush_pend=0, timeout counter=0, o_valid_m=0,
//    o_dataout=0, o_lanes=0, o_last=0, o_busy=0. Reset mid-word discards all held data, no output emitted.
//  - Input beat accepted when i_valid_s & o_ready_s. Lane 0 = first accepted beat (LSB), filled in order.
//  - out_stall = o_valid_m & ~i_ready_m. o_ready_s = ~flush_pend & ~(out_stall & lane_cnt==RATIO-1).
//    o_ready_s is combinational from i_ready_m; no combinational path from i_valid_s to o_ready_s.
//  - Beat completing lane RATIO-1: next cycle o_valid_m=1, o_dataout={i_datain, acc lanes}, o_lanes=RATIO,
//    o_last=0, lane_cnt=0. Latency: last beat accepted at cycle N -> o_valid_m at N+1. Full throughput:
//    one narrow beat per cycle sustained while i_ready_m=1 (back-to-back wide words every RATIO cycles).
//  - Output holds o_dataout/o_lanes/o_last stable while out_stall; o_valid_m drops only after consume.
//  - Flush: on i_flush, if post-cycle lane count (incl. same-cycle accepted beat) is 0 -> ignored;
//    else flush_pend=1. Flush pending drives o_ready_s=0. When output register free (~out_stall), load
//    partial word: used lanes as held, unused lanes zero, o_lanes=lane_cnt, o_last=1; clear lane_cnt,
//    accumulator, flush_pend. If a same-cycle beat completes the word, flush is a no-op (full word, o_last=0).
//  - Timeout (TIMEOUT>0): counter clears on every accepted beat or when lane_cnt==0; increments each cycle
//    lane_cnt>0 and no beat accepted; reaching TIMEOUT sets flush_pend exactly as i_flush. Saturates.
//  - i_flush while flush_pend=1: no additional effect. i_flush with lane_cnt=0 and empty output: no-op.
//  - States: FILL (lane_cnt 0..RATIO-1, flush_pend=0) -> FLUSH (flush_pend=1) -> FILL on partial load.
//  - o_busy = (lane_cnt!=0) | o_valid_m | flush_pend.
// TESTING
//  1. RATIO=4, DATA_WIDTH=8, i_ready_m=1, beats 0x11,0x22,0x33,0x44 -> 1 cycle after 4th beat
//     o_valid_m=1, o_dataout=0x44332211, o_lanes=4, o_last=0 for one cycle.
//  2. Stream 12 beats continuous, i_ready_m=1 -> o_ready_s stays 1, 3 wide words, no gaps, order preserved.
//  3. Hold i_ready_m=0 with a word pending, send 4 more beats -> o_ready_s=0 on 4th (lane 3) only;
//     output stable; raising i_ready_m accepts lane 3 that cycle, new word next cycle.
//  4. Beats 0xA1,0xB2 then i_flush -> o_ready_s=0 while pending; o_dataout=0x0000B2A1, o_lanes=2, o_last=1.
//  5. TIMEOUT=16, one beat 0x5C then idle -> auto-flush after 16 idle cycles: o_lanes=1, o_last=1, data 0x5C.
//  6. Assert i_rst_n=0 with 3 lanes held and output stalled -> all outputs 0 immediately; no stale word after reset.

Source files
------------

// File: rtl/sync_fifo_rd_packer.sv
// Purpose: pops narrow words from a sync_fifo read port and packs RATIO of them into one wide word.
// Latency: 1 cycle from the beat that fills the last lane, or from the flush-pending cycle, to o_valid_m.
// Backpressure: o_ready_s drops while a flush is pending, or when the output is stalled and the next beat would fill the last lane.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_valid_s/o_ready_s     narrow input handshake, data on i_datain (lane 0 = first beat, LSB)
//   i_flush                 single-cycle request to emit the held partial word
//   o_valid_m/i_ready_m     wide output handshake; o_dataout, o_lanes (1..RATIO), o_last (flush/timeout word)
//   o_busy                  partial data held, flush pending, or output word pending
module sync_fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = $clog2(RATIO + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid_s,
    input  logic [DATA_WIDTH-1:0]       i_datain,
    output logic                        o_ready_s,
    input  logic                        i_flush,
    output logic                        o_valid_m,
    output logic [RATIO*DATA_WIDTH-1:0] o_dataout,
    output logic [CNT_WIDTH-1:0]        o_lanes,
    output logic                        o_last,
    input  logic                        i_ready_m,
    output logic                        o_busy
);

    localparam int OW = RATIO * DATA_WIDTH;
    // Wide enough to hold TIMEOUT, and still legal when TIMEOUT is 0.
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] lane_cnt, lane_cnt_next;
    logic [OW-1:0]        acc, acc_next;
    logic [TW-1:0]        tcnt, tcnt_next;

    logic                 vld_next;
    logic [OW-1:0]        dout_next;
    logic [CNT_WIDTH-1:0] lanes_next;
    logic                 last_next;

    logic                 out_stall;
    logic                 at_top;
    logic                 accept;
    logic                 completing;
    logic                 load_partial;
    logic                 timeout_hit;
    logic                 flush_req;
    logic [CNT_WIDTH-1:0] post_cnt;

    assign out_stall    = o_valid_m & ~i_ready_m;
    assign at_top       = (lane_cnt == CNT_WIDTH'(RATIO - 1));
    // Only the beat that would need the output register is held off by a stall;
    // earlier lanes keep filling the accumulator behind a stalled word.
    assign o_ready_s    = (state == FILL) & ~(out_stall & at_top);
    assign accept       = i_valid_s & o_ready_s;
    assign completing   = accept & at_top;
    assign load_partial = (state == FLUSH) & ~out_stall;
    // Gated by lane_cnt so a saturated count left over from a flushed word never re-fires.
    assign timeout_hit  = (TIMEOUT > 0) && (tcnt == TW'(TIMEOUT)) && (lane_cnt != '0);
    assign flush_req    = i_flush | timeout_hit;
    // Lane count as it will stand after this cycle; a completing beat empties the accumulator.
    assign post_cnt     = completing ? '0 : (lane_cnt + CNT_WIDTH'(accept));
    assign o_busy       = (lane_cnt != '0) | o_valid_m | (state == FLUSH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= FILL;
            lane_cnt  <= '0;
            acc       <= '0;
            tcnt      <= '0;
            o_valid_m <= 1'b0;
            o_dataout <= '0;
            o_lanes   <= '0;
            o_last    <= 1'b0;
        end else begin
            state     <= state_next;
            lane_cnt  <= lane_cnt_next;
            acc       <= acc_next;
            tcnt      <= tcnt_next;
            o_valid_m <= vld_next;
            o_dataout <= dout_next;
            o_lanes   <= lanes_next;
            o_last    <= last_next;
        end
    end

    always_comb begin
        state_next    = state;
        lane_cnt_next = lane_cnt;
        acc_next      = acc;
        tcnt_next     = tcnt;
        vld_next      = out_stall;
        dout_next     = o_dataout;
        lanes_next    = o_lanes;
        last_next     = o_last;

        case (state)
            FILL: begin
                if (flush_req && (post_cnt != '0)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_stall) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase

        if (completing) begin
            // Lane RATIO-1 of acc is always zero, so the new beat just drops in on top.
            vld_next      = 1'b1;
            dout_next     = acc;
            dout_next[(RATIO-1)*DATA_WIDTH +: DATA_WIDTH] = i_datain;
            lanes_next    = CNT_WIDTH'(RATIO);
            last_next     = 1'b0;
            lane_cnt_next = '0;
            acc_next      = '0;
        end else if (accept) begin
            for (int k = 0; k < RATIO - 1; k++) begin
                if (lane_cnt == CNT_WIDTH'(k)) begin
                    acc_next[k*DATA_WIDTH +: DATA_WIDTH] = i_datain;
                end
            end
            lane_cnt_next = lane_cnt + CNT_WIDTH'(1);
        end

        // Input is blocked in FLUSH, so this never coincides with an accepted beat.
        if (load_partial) begin
            vld_next      = 1'b1;
            dout_next     = acc;
            lanes_next    = lane_cnt;
            last_next     = 1'b1;
            lane_cnt_next = '0;
            acc_next      = '0;
        end

        if (accept || (lane_cnt == '0) || load_partial) begin
            tcnt_next = '0;
        end else if (tcnt != TW'(TIMEOUT)) begin
            tcnt_next = tcnt + TW'(1);
        end
    end

endmodule
